// File: rtl/sbus_arbiter_pkg.sv
// Shared definitions for the sbus arbiter: rw encoding, sequencer states and
// grant bit positions.
package sbus_defs;

   localparam logic SBUS_RW_READ  = 1'b1;
   localparam logic SBUS_RW_WRITE = 1'b0;

   localparam int GNT_USB = 0;
   localparam int GNT_LOC = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_DONE
   } sbus_state_t;

endpackage

// File: rtl/sbus_req_latch.sv
// One requester's slot: captures a start_op pulse, holds it pending until the
// arbiter completes it, and keeps the last read result for that requester.
module sbus_req_latch
   import sbus_defs::*;
#(
   parameter int ADDR_WIDTH = 41,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_op,
   input  logic                  rw,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  done,
   input  logic [DATA_WIDTH-1:0] done_rdata,
   output logic                  ready,
   output logic                  pending,
   output logic                  slot_rw,
   output logic [ADDR_WIDTH-1:0] slot_address,
   output logic [DATA_WIDTH-1:0] slot_wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic capture;

   assign capture = start_op && !pending;
   assign ready   = !pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
         rdata   <= '0;
      end else begin
         if (capture) begin
            pending <= 1'b1;
         end else if (done) begin
            pending <= 1'b0;
         end
         if (done && slot_rw == SBUS_RW_READ) begin
            rdata <= done_rdata;
         end
      end
   end

   // Slot contents are only looked at while pending, so they need no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         slot_rw      <= rw;
         slot_address <= address;
         slot_wdata   <= wdata;
      end
   end

endmodule

// File: rtl/sbus_arbiter.sv
// Round-robin arbiter sharing one sbus storage target between the stierlitz
// USB bridge and a local client, with a watchdog on target completion.
module sbus_arbiter
   import sbus_defs::*;
#(
   parameter int ADDR_WIDTH     = 41,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  usb_start_op,
   input  logic                  usb_rw,
   input  logic [ADDR_WIDTH-1:0] usb_address,
   inout  wire  [DATA_WIDTH-1:0] usb_data,
   output logic                  usb_ready,
   input  logic                  loc_start_op,
   input  logic                  loc_rw,
   input  logic [ADDR_WIDTH-1:0] loc_address,
   input  logic [DATA_WIDTH-1:0] loc_wdata,
   output logic [DATA_WIDTH-1:0] loc_rdata,
   output logic                  loc_ready,
   output logic                  mem_start_op,
   output logic                  mem_rw,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic [1:0]            grant,
   output logic                  timeout_err
);

   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);

   sbus_state_t           state, next_state;
   logic                  usb_pending, loc_pending;
   logic                  usb_slot_rw, loc_slot_rw;
   logic [ADDR_WIDTH-1:0] usb_slot_address, loc_slot_address;
   logic [DATA_WIDTH-1:0] usb_slot_wdata, loc_slot_wdata;
   logic [DATA_WIDTH-1:0] usb_rdata, done_rdata;
   logic                  last_loc, pick_loc, abort, wdog_hit, in_done;
   logic [WDOG_W-1:0]     wdog;

   assign in_done  = (state == ST_DONE);
   assign wdog_hit = (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
   assign usb_data = (usb_rw == SBUS_RW_READ) ? usb_rdata : {DATA_WIDTH{1'bz}};

   sbus_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_usb (
      .clk(clk), .reset(reset), .start_op(usb_start_op), .rw(usb_rw),
      .address(usb_address), .wdata(usb_data),
      .done(in_done && grant[GNT_USB]), .done_rdata(done_rdata),
      .ready(usb_ready), .pending(usb_pending), .slot_rw(usb_slot_rw),
      .slot_address(usb_slot_address), .slot_wdata(usb_slot_wdata),
      .rdata(usb_rdata)
   );

   sbus_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_loc (
      .clk(clk), .reset(reset), .start_op(loc_start_op), .rw(loc_rw),
      .address(loc_address), .wdata(loc_wdata),
      .done(in_done && grant[GNT_LOC]), .done_rdata(done_rdata),
      .ready(loc_ready), .pending(loc_pending), .slot_rw(loc_slot_rw),
      .slot_address(loc_slot_address), .slot_wdata(loc_slot_wdata),
      .rdata(loc_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      pick_loc   = 1'b0;
      abort      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (usb_pending || loc_pending) begin
               next_state = ST_ISSUE;
               pick_loc   = loc_pending && (!usb_pending || !last_loc);
            end
         end
         ST_ISSUE: next_state = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (wdog_hit) begin
               next_state = ST_DONE;
               abort      = 1'b1;
            end else if (!mem_ready) begin
               next_state = ST_WAIT_DONE;
            end
         end
         // A real completion on the last watchdog cycle still counts as success.
         ST_WAIT_DONE: begin
            if (mem_ready) begin
               next_state = ST_DONE;
            end else if (wdog_hit) begin
               next_state = ST_DONE;
               abort      = 1'b1;
            end
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_start_op <= 1'b0;
         mem_rw       <= 1'b0;
         mem_address  <= '0;
         mem_wdata    <= '0;
         grant        <= '0;
         last_loc     <= 1'b1;
         wdog         <= '0;
         done_rdata   <= '0;
         timeout_err  <= 1'b0;
      end else begin
         mem_start_op <= (next_state == ST_ISSUE);
         case (state)
            ST_IDLE: begin
               if (next_state == ST_ISSUE) begin
                  if (pick_loc) begin
                     grant       <= 2'b10;
                     mem_rw      <= loc_slot_rw;
                     mem_address <= loc_slot_address;
                     mem_wdata   <= loc_slot_wdata;
                  end else begin
                     grant       <= 2'b01;
                     mem_rw      <= usb_slot_rw;
                     mem_address <= usb_slot_address;
                     mem_wdata   <= usb_slot_wdata;
                  end
               end
            end
            ST_ISSUE: wdog <= '0;
            ST_WAIT_ACK, ST_WAIT_DONE: begin
               wdog <= wdog + 1'b1;
               if (abort) begin
                  done_rdata  <= '0;
                  timeout_err <= 1'b1;
               end else if (state == ST_WAIT_DONE && mem_ready) begin
                  done_rdata <= mem_rdata;
               end
            end
            ST_DONE: begin
               grant    <= '0;
               last_loc <= grant[GNT_LOC];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sbus_arbiter.sv
// Bench for sbus_arbiter: table of request rounds against a small storage
// target model, scoreboard of expected target operations, plus corner sequences.
module tb_sbus_arbiter;

   localparam int AW = 41;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          usb_start_op, usb_rw;
   logic [AW-1:0] usb_address;
   logic [DW-1:0] usb_wd;
   wire  [DW-1:0] usb_data;
   logic          usb_ready;
   logic          loc_start_op, loc_rw;
   logic [AW-1:0] loc_address;
   logic [DW-1:0] loc_wdata, loc_rdata;
   logic          loc_ready;
   logic          mem_start_op, mem_rw;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = 8'h00;
   logic          mem_ready = 1'b1;
   logic [1:0]    grant;
   logic          timeout_err;

   assign usb_data = usb_rw ? {DW{1'bz}} : usb_wd;

   sbus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .usb_start_op(usb_start_op), .usb_rw(usb_rw), .usb_address(usb_address),
      .usb_data(usb_data), .usb_ready(usb_ready),
      .loc_start_op(loc_start_op), .loc_rw(loc_rw), .loc_address(loc_address),
      .loc_wdata(loc_wdata), .loc_rdata(loc_rdata), .loc_ready(loc_ready),
      .mem_start_op(mem_start_op), .mem_rw(mem_rw), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant(grant), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Storage target: drops ready one cycle after start, completes three later.
   logic          tgt_hang = 1'b0;
   logic          tgt_busy = 1'b0;
   logic          tgt_loaded = 1'b0;
   int            tgt_cnt = 0;
   int            rise_cyc = 0;
   logic          t_rw;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wd;
   logic [DW-1:0] tmem [logic [AW-1:0]];

   always @(negedge clk) begin
      if (!tgt_loaded) begin
         tmem[41'h100]     = 8'hAA;
         tmem[41'h101]     = 8'h33;
         tmem[{AW{1'b1}}]  = 8'hC5;
         tgt_loaded        = 1'b1;
      end
      if (mem_start_op && !tgt_hang) begin
         t_rw     = mem_rw;
         t_addr   = mem_address;
         t_wd     = mem_wdata;
         tgt_cnt  = 0;
         tgt_busy = 1'b1;
      end else if (tgt_busy) begin
         tgt_cnt++;
         if (tgt_cnt == 1) begin
            mem_ready = 1'b0;
         end else if (tgt_cnt == 4) begin
            if (t_rw) mem_rdata = tmem.exists(t_addr) ? tmem[t_addr] : 8'h00;
            else tmem[t_addr] = t_wd;
            mem_ready = 1'b1;
            tgt_busy  = 1'b0;
            rise_cyc  = cyc;
         end
      end
   end

   typedef struct {
      logic [1:0]    g;
      logic          rw;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } op_t;

   op_t  exp_q[$];
   logic m_last_loc = 1'b1;

   always @(negedge clk) begin : monitor
      op_t e;
      if (mem_start_op) begin
         if (exp_q.size() == 0) begin
            check("unexpected_mem_start_op", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("op_grant", grant, e.g);
            check("op_rw", mem_rw, e.rw);
            check("op_address", mem_address, e.a);
            if (!e.rw) check("op_wdata", mem_wdata, e.d);
         end
      end
   end

   typedef struct {
      logic          u_go, u_rw;
      logic [AW-1:0] u_a;
      logic [DW-1:0] u_d;
      logic          l_go, l_rw;
      logic [AW-1:0] l_a;
      logic [DW-1:0] l_d;
      logic [DW-1:0] exp_u, exp_l;
   } vec_t;

   function automatic vec_t mk(input logic u_go, input logic u_rw, input logic [AW-1:0] u_a,
                               input logic [DW-1:0] u_d, input logic l_go, input logic l_rw,
                               input logic [AW-1:0] l_a, input logic [DW-1:0] l_d,
                               input logic [DW-1:0] exp_u, input logic [DW-1:0] exp_l);
      vec_t v;
      v.u_go = u_go; v.u_rw = u_rw; v.u_a = u_a; v.u_d = u_d;
      v.l_go = l_go; v.l_rw = l_rw; v.l_a = l_a; v.l_d = l_d;
      v.exp_u = exp_u; v.exp_l = exp_l;
      return v;
   endfunction

   task automatic push_op(input logic is_loc, input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      op_t e;
      e.g  = is_loc ? 2'b10 : 2'b01;
      e.rw = rw;
      e.a  = a;
      e.d  = d;
      exp_q.push_back(e);
   endtask

   // Drives one cycle of start_op pulses; expected target order follows round-robin.
   task automatic issue(input vec_t v);
      usb_start_op = v.u_go;
      loc_start_op = v.l_go;
      if (v.u_go) begin
         usb_rw = v.u_rw; usb_address = v.u_a; usb_wd = v.u_d;
      end
      if (v.l_go) begin
         loc_rw = v.l_rw; loc_address = v.l_a; loc_wdata = v.l_d;
      end
      if (v.u_go && v.l_go) begin
         if (m_last_loc) begin
            push_op(1'b0, v.u_rw, v.u_a, v.u_d);
            push_op(1'b1, v.l_rw, v.l_a, v.l_d);
            m_last_loc = 1'b1;
         end else begin
            push_op(1'b1, v.l_rw, v.l_a, v.l_d);
            push_op(1'b0, v.u_rw, v.u_a, v.u_d);
            m_last_loc = 1'b0;
         end
      end else if (v.u_go) begin
         push_op(1'b0, v.u_rw, v.u_a, v.u_d);
         m_last_loc = 1'b0;
      end else if (v.l_go) begin
         push_op(1'b1, v.l_rw, v.l_a, v.l_d);
         m_last_loc = 1'b1;
      end
      @(negedge clk);
      usb_start_op = 1'b0;
      loc_start_op = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(usb_ready && loc_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_completes"}, (n < 200), 1'b1);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      issue(v);
      wait_idle(name);
      usb_rw = 1'b1;
      #1;
      check({name, "_usb_rdata"}, usb_data, v.exp_u);
      check({name, "_loc_rdata"}, loc_rdata, v.exp_l);
      check({name, "_all_served"}, exp_q.size(), 0);
   endtask

   vec_t vt[8];
   vec_t hv;
   int   t0, s0;

   initial begin : global_bound
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      vt[0] = mk(1, 1, 41'h100, 8'h00, 1, 1, 41'h101, 8'h00, 8'hAA, 8'h33);
      vt[1] = mk(1, 0, 41'h300, 8'h11, 1, 0, 41'h301, 8'h22, 8'hAA, 8'h33);
      vt[2] = mk(1, 1, 41'h301, 8'h00, 1, 1, 41'h300, 8'h00, 8'h22, 8'h11);
      vt[3] = mk(0, 0, 41'h0,   8'h00, 1, 0, 41'h400, 8'h77, 8'h22, 8'h11);
      vt[4] = mk(0, 0, 41'h0,   8'h00, 1, 1, 41'h400, 8'h00, 8'h22, 8'h77);
      vt[5] = mk(1, 1, 41'h400, 8'h00, 1, 1, 41'h100, 8'h00, 8'h77, 8'hAA);
      vt[6] = mk(1, 1, {AW{1'b1}}, 8'h00, 0, 0, 41'h0, 8'h00, 8'hC5, 8'hAA);
      vt[7] = mk(1, 0, 41'h500, 8'h99, 0, 0, 41'h0, 8'h00, 8'hC5, 8'hAA);

      reset = 1'b1;
      usb_start_op = 1'b0; usb_rw = 1'b0; usb_address = '0; usb_wd = '0;
      loc_start_op = 1'b0; loc_rw = 1'b0; loc_address = '0; loc_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_usb_ready", usb_ready, 1'b1);
      check("rst_loc_ready", loc_ready, 1'b1);
      check("rst_grant", grant, 2'b00);
      check("rst_mem_start_op", mem_start_op, 1'b0);
      check("rst_timeout_err", timeout_err, 1'b0);
      check("rst_loc_rdata", loc_rdata, 8'h00);
      check("rst_mem_address", mem_address, 41'h0);
      usb_rw = 1'b1;
      #1;
      check("rst_usb_rdata", usb_data, 8'h00);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // Single usb write: start latency and ready-return latency.
      @(negedge clk);
      t0 = cyc;
      issue(mk(1, 0, 41'h200, 8'h5A, 0, 0, 41'h0, 8'h00, 8'h00, 8'h00));
      check("wr_usb_ready_low", usb_ready, 1'b0);
      check("wr_start_not_early", mem_start_op, 1'b0);
      @(negedge clk);
      check("wr_start_latency", cyc - t0, 2);
      check("wr_start_high", mem_start_op, 1'b1);
      check("wr_address", mem_address, 41'h200);
      check("wr_wdata", mem_wdata, 8'h5A);
      @(negedge clk);
      check("wr_start_one_cycle", mem_start_op, 1'b0);
      wait_idle("wr");
      check("wr_ready_delay", cyc - rise_cyc, 2);

      // Non-owner request arriving mid-operation is served next.
      @(negedge clk);
      issue(mk(1, 1, 41'h101, 8'h00, 0, 0, 41'h0, 8'h00, 8'h00, 8'h00));
      repeat (2) @(negedge clk);
      issue(mk(0, 0, 41'h0, 8'h00, 1, 1, 41'h200, 8'h00, 8'h00, 8'h00));
      wait_idle("midop");
      usb_rw = 1'b1;
      #1;
      check("midop_usb_rdata", usb_data, 8'h33);
      check("midop_loc_rdata", loc_rdata, 8'h5A);

      // Target never acknowledges: watchdog abort.
      check("terr_clear_before", timeout_err, 1'b0);
      tgt_hang = 1'b1;
      @(negedge clk);
      issue(mk(0, 0, 41'h0, 8'h00, 1, 1, 41'h100, 8'h00, 8'h00, 8'h00));
      @(negedge clk);
      check("to_start_high", mem_start_op, 1'b1);
      s0 = cyc;
      wait_idle("to");
      check("to_abort_latency", cyc - s0, 10);
      check("to_timeout_err", timeout_err, 1'b1);
      check("to_loc_rdata_zero", loc_rdata, 8'h00);
      check("to_loc_ready", loc_ready, 1'b1);
      tgt_hang = 1'b0;
      run_vec(mk(1, 1, 41'h200, 8'h00, 0, 0, 41'h0, 8'h00, 8'h5A, 8'h00), "after_to");
      check("to_err_sticky", timeout_err, 1'b1);

      // Reset while waiting for completion; stale completion must be ignored.
      @(negedge clk);
      issue(mk(1, 1, 41'h101, 8'h00, 0, 0, 41'h0, 8'h00, 8'h00, 8'h00));
      repeat (3) @(negedge clk);
      check("rmid_in_op_grant", grant, 2'b01);
      check("rmid_target_busy", mem_ready, 1'b0);
      reset = 1'b1;
      #1;
      check("rmid_usb_ready", usb_ready, 1'b1);
      check("rmid_loc_ready", loc_ready, 1'b1);
      check("rmid_grant", grant, 2'b00);
      check("rmid_mem_start_op", mem_start_op, 1'b0);
      check("rmid_timeout_err", timeout_err, 1'b0);
      check("rmid_usb_rdata", usb_data, 8'h00);
      check("rmid_loc_rdata", loc_rdata, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      m_last_loc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("rmid_quiet%0d", i),
               {usb_ready, loc_ready, grant, mem_start_op}, 5'b11000);
      end
      run_vec(mk(1, 1, 41'h100, 8'h00, 0, 0, 41'h0, 8'h00, 8'hAA, 8'h00), "after_rst");

      check("no_lost_requests", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
